cache_stream_loader: RTL and testbench



---
 rtl/cache_stream_loader_pkg.sv | 25 ++
 rtl/cache_stream_loader_packer.sv | 50 +++++
 rtl/cache_stream_loader.sv | 139 +++++++++++++
 tb/tb_cache_stream_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stream_loader_pkg.sv
// Shared types and constants for the byte-stream-to-cache loader.
package cache_stream_loader_pkg;

    // Load sequencing states
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        SETTLE,
        DONE
    } loader_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_BITS  = $clog2(WORD_BYTES);

    // Cache write_enable encodings
    localparam logic [WORD_BYTES-1:0] CACHE_WE_NONE = 4'b0000;
    localparam logic [WORD_BYTES-1:0] CACHE_WE_WORD = 4'b1111;

    // One-hot byte-lane select for a lane index
    function automatic logic [WORD_BYTES-1:0] lane_onehot(input logic [LANE_BITS-1:0] lane);
        return CACHE_WE_NONE | (WORD_BYTES'(1) << lane);
    endfunction

endpackage

// File: rtl/cache_stream_loader_packer.sv
// Byte-lane packer: accumulates bytes into a 32-bit word with a lane mask.
// The *_next outputs already include the byte inserted this cycle, so the
// caller can capture a complete word in the same cycle the last byte lands.
module cache_stream_loader_packer
    import cache_stream_loader_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      insert_i,
    input  logic [LANE_BITS-1:0]      lane_i,
    input  logic [7:0]                byte_i,
    output logic [8*WORD_BYTES-1:0]   data_next_o,
    output logic [WORD_BYTES-1:0]     mask_next_o,
    output logic                      fills_o
);

    logic [8*WORD_BYTES-1:0] data_q, data_d;
    logic [WORD_BYTES-1:0]   mask_q, mask_d;

    // Merge the incoming byte into its lane and set the matching mask bit
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (insert_i) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (lane_i == LANE_BITS'(i)) begin
                    data_d[8*i +: 8] = byte_i;
                end
            end
            mask_d = mask_q | lane_onehot(lane_i);
        end
    end

    // Lane storage; clear zeroes data too so unused lanes read back as 0
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            data_q <= '0;
            mask_q <= CACHE_WE_NONE;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign data_next_o = data_d;
    assign mask_next_o = mask_d;
    assign fills_o     = insert_i && (lane_i == LANE_BITS'(WORD_BYTES - 1));

endmodule

// File: rtl/cache_stream_loader.sv
// Loads a byte stream into memory through the Cache CPU-side port, packing
// bytes little-endian into byte-masked word writes and flagging completion.
module cache_stream_loader
    import cache_stream_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH = 32,
    parameter int unsigned LENGTH_BITWIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDRESS_BITWIDTH-1:0] start_address,
    input  logic [LENGTH_BITWIDTH-1:0]  length,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        done,
    output logic [ADDRESS_BITWIDTH-1:0] cache_address,
    output logic [8*WORD_BYTES-1:0]     cache_data_in,
    output logic [WORD_BYTES-1:0]       cache_write_enable,
    input  logic                        cache_busy
);

    loader_state_e                 state_q;
    logic [ADDRESS_BITWIDTH-1:0]   ptr_q;
    logic [LENGTH_BITWIDTH-1:0]    remaining_q;
    logic                          in_ready_q;
    logic                          done_q;
    logic [ADDRESS_BITWIDTH-1:0]   addr_q;
    logic [8*WORD_BYTES-1:0]       data_q;
    logic [WORD_BYTES-1:0]         we_q;

    logic                          accept_d;
    logic                          last_byte_d;
    logic                          take_d;
    logic                          load_start_d;
    logic                          pack_clear_d;
    logic [8*WORD_BYTES-1:0]       pack_data_d;
    logic [WORD_BYTES-1:0]         pack_mask_d;
    logic                          pack_fills_d;
    logic [ADDRESS_BITWIDTH-1:0]   word_addr_d;

    // Handshake, request-taken and load-start qualifiers
    always_comb begin
        accept_d     = in_ready_q && in_valid;
        last_byte_d  = (remaining_q == LENGTH_BITWIDTH'(1));
        take_d       = (state_q == ISSUE) && !cache_busy;
        load_start_d = start && ((state_q == IDLE) || (state_q == DONE))
                       && (length != '0);
        pack_clear_d = take_d || load_start_d;
        word_addr_d  = {ptr_q[ADDRESS_BITWIDTH-1:LANE_BITS], LANE_BITS'(0)};
    end

    cache_stream_loader_packer u_packer (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (pack_clear_d),
        .insert_i    (accept_d),
        .lane_i      (ptr_q[LANE_BITS-1:0]),
        .byte_i      (in_data),
        .data_next_o (pack_data_d),
        .mask_next_o (pack_mask_d),
        .fills_o     (pack_fills_d)
    );

    // Load sequencer with registered handshake and cache request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= CACHE_WE_NONE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q       <= start_address;
                            remaining_q <= length;
                            state_q     <= COLLECT;
                            in_ready_q  <= 1'b1;
                            done_q      <= 1'b0;
                        end
                    end
                end
                COLLECT: begin
                    if (accept_d) begin
                        ptr_q       <= ptr_q + ADDRESS_BITWIDTH'(1);
                        remaining_q <= remaining_q - LENGTH_BITWIDTH'(1);
                        // All bytes of a word share the upper pointer bits, so
                        // the current pointer yields the word address.
                        if (pack_fills_d || last_byte_d) begin
                            state_q    <= ISSUE;
                            in_ready_q <= 1'b0;
                            addr_q     <= word_addr_d;
                            data_q     <= pack_data_d;
                            we_q       <= pack_mask_d;
                        end
                    end
                end
                ISSUE: begin
                    if (take_d) begin
                        we_q    <= CACHE_WE_NONE;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (remaining_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= COLLECT;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b0;
                    we_q       <= CACHE_WE_NONE;
                end
            endcase
        end
    end

    assign in_ready           = in_ready_q;
    assign done               = done_q;
    assign cache_address      = addr_q;
    assign cache_data_in      = data_q;
    assign cache_write_enable = we_q;

endmodule

// File: tb/tb_cache_stream_loader.sv
// Directed self-checking bench for cache_stream_loader with a simple
// word-memory cache model that can hold busy on a chosen address.
module tb_cache_stream_loader;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_address;
    logic [LW-1:0] length;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          done;
    logic [AW-1:0] cache_address;
    logic [31:0]   cache_data_in;
    logic [3:0]    cache_write_enable;
    logic          cache_busy;

    cache_stream_loader #(
        .ADDRESS_BITWIDTH (AW),
        .LENGTH_BITWIDTH  (LW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .start_address      (start_address),
        .length             (length),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .done               (done),
        .cache_address      (cache_address),
        .cache_data_in      (cache_data_in),
        .cache_write_enable (cache_write_enable),
        .cache_busy         (cache_busy)
    );

    always #5 clk = ~clk;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [31:0] mem [0:255];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [3:0]  wr_we_q   [$];
    logic [7:0]  tx_bytes  [$];

    logic [31:0] stall_addr  = 32'hFFFF_FFFF;
    int unsigned stall_left  = 0;
    int unsigned held_cnt    = 0;
    int unsigned unstable    = 0;
    int unsigned late_drop   = 0;
    int unsigned ready_bad   = 0;

    logic        prev_busy   = 1'b0;
    logic        prev_taken  = 1'b0;
    logic [3:0]  prev_we     = 4'b0;
    logic [31:0] prev_addr   = 32'b0;
    logic [31:0] prev_data   = 32'b0;

    // Cache model: decides busy, records taken requests, applies byte writes
    initial begin
        cache_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_left != 0 && cache_write_enable != 4'b0 && cache_address == stall_addr) begin
                cache_busy = 1'b1;
                stall_left = stall_left - 1;
            end else begin
                cache_busy = 1'b0;
            end
            if (prev_busy && prev_we != 4'b0 &&
                (cache_write_enable != prev_we || cache_address != prev_addr || cache_data_in != prev_data))
                unstable = unstable + 1;
            if (prev_taken && cache_write_enable != 4'b0)
                late_drop = late_drop + 1;
            if (in_ready && (cache_write_enable != 4'b0 || prev_taken))
                ready_bad = ready_bad + 1;
            if (cache_write_enable != 4'b0 && cache_busy)
                held_cnt = held_cnt + 1;
            prev_taken = (cache_write_enable != 4'b0) && !cache_busy;
            if (prev_taken) begin
                wr_addr_q.push_back(cache_address);
                wr_data_q.push_back(cache_data_in);
                wr_we_q.push_back(cache_write_enable);
                for (int l = 0; l < 4; l++)
                    if (cache_write_enable[l])
                        mem[cache_address[9:2]][8*l +: 8] = cache_data_in[8*l +: 8];
            end
            prev_busy = cache_busy;
            prev_we   = cache_write_enable;
            prev_addr = cache_address;
            prev_data = cache_data_in;
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_we_q.delete();
        held_cnt  = 0;
        unstable  = 0;
        late_drop = 0;
        ready_bad = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        @(negedge clk);
        start_address = addr;
        length        = len;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    // Drive tx_bytes; when stalled, in_valid drops for 1 or 2 cycles between bytes
    task automatic send_stream(input bit stalled);
        int unsigned n;
        bit          timed_out = 0;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            @(negedge clk);
            if (stalled && i > 0) begin
                in_valid = 1'b0;
                repeat ((i % 2 == 1) ? 2 : 1) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = tx_bytes[i];
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                timed_out = 1;
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_accept: in_ready timeout, got timeout=%0b want 0", timed_out);
        end
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done: done=%b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start_address = '0; length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run += 5;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        if (cache_address !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", cache_address); end
        if (cache_data_in !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", cache_data_in); end
        if (cache_write_enable !== 4'h0) begin tests_failed++; $display("FAIL reset_we: got %b want 0000", cache_write_enable); end
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start(32'd500, 16'd0);
        tests_run += 2;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_len_done: got %b want 1", done); end
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL zero_len_ready: got %b want 0", in_ready); end
        repeat (4) @(negedge clk);
        tests_run++;
        if (wr_addr_q.size() != 0) begin tests_failed++; $display("FAIL zero_len_writes: got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_aligned();
        clear_log();
        pulse_start(32'd64, 16'd8);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL aligned_done_drop: got %b want 0", done); end
        tx_bytes = '{8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h78, 8'h56, 8'h34, 8'h12};
        send_stream(1'b0);
        wait_done("aligned");
        tests_run += 9;
        if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL aligned_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q[0] !== 32'd64) begin tests_failed++; $display("FAIL aligned_addr0: got %h want 40", wr_addr_q[0]); end
        if (wr_data_q[0] !== 32'hABCDEF12) begin tests_failed++; $display("FAIL aligned_data0: got %h want abcdef12", wr_data_q[0]); end
        if (wr_we_q[0] !== 4'b1111) begin tests_failed++; $display("FAIL aligned_we0: got %b want 1111", wr_we_q[0]); end
        if (wr_addr_q[1] !== 32'd68) begin tests_failed++; $display("FAIL aligned_addr1: got %h want 44", wr_addr_q[1]); end
        if (wr_data_q[1] !== 32'h12345678) begin tests_failed++; $display("FAIL aligned_data1: got %h want 12345678", wr_data_q[1]); end
        if (wr_we_q[1] !== 4'b1111) begin tests_failed++; $display("FAIL aligned_we1: got %b want 1111", wr_we_q[1]); end
        if (mem[16] !== 32'hABCDEF12) begin tests_failed++; $display("FAIL aligned_read64: got %h want abcdef12", mem[16]); end
        if (late_drop != 0) begin tests_failed++; $display("FAIL aligned_we_drop: got %0d late cycles want 0", late_drop); end
    endtask

    task automatic test_unaligned();
        clear_log();
        mem[2] = 32'h11223344;
        mem[3] = 32'h55667788;
        pulse_start(32'd9, 16'd4);
        tx_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(1'b0);
        wait_done("unaligned");
        tests_run += 9;
        if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL unal_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q[0] !== 32'd8) begin tests_failed++; $display("FAIL unal_addr0: got %h want 8", wr_addr_q[0]); end
        if (wr_data_q[0] !== 32'hCCBBAA00) begin tests_failed++; $display("FAIL unal_data0: got %h want ccbbaa00", wr_data_q[0]); end
        if (wr_we_q[0] !== 4'b1110) begin tests_failed++; $display("FAIL unal_we0: got %b want 1110", wr_we_q[0]); end
        if (wr_addr_q[1] !== 32'd12) begin tests_failed++; $display("FAIL unal_addr1: got %h want c", wr_addr_q[1]); end
        if (wr_data_q[1] !== 32'h000000DD) begin tests_failed++; $display("FAIL unal_data1: got %h want 000000dd", wr_data_q[1]); end
        if (wr_we_q[1] !== 4'b0001) begin tests_failed++; $display("FAIL unal_we1: got %b want 0001", wr_we_q[1]); end
        if (mem[2] !== 32'hCCBBAA44) begin tests_failed++; $display("FAIL unal_read8: got %h want ccbbaa44", mem[2]); end
        if (mem[3] !== 32'h556677DD) begin tests_failed++; $display("FAIL unal_read12: got %h want 556677dd", mem[3]); end
    endtask

    task automatic test_miss();
        clear_log();
        mem[4] = 32'hFEEDFACE;
        stall_addr = 32'd16;
        stall_left = 3;
        pulse_start(32'd16, 16'd4);
        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_stream(1'b0);
        wait_done("miss");
        tests_run += 8;
        if (wr_addr_q.size() != 1) begin tests_failed++; $display("FAIL miss_count: got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q[0] !== 32'd16) begin tests_failed++; $display("FAIL miss_addr: got %h want 10", wr_addr_q[0]); end
        if (wr_data_q[0] !== 32'h04030201) begin tests_failed++; $display("FAIL miss_data: got %h want 04030201", wr_data_q[0]); end
        if (wr_we_q[0] !== 4'b1111) begin tests_failed++; $display("FAIL miss_we: got %b want 1111", wr_we_q[0]); end
        if (held_cnt != 3) begin tests_failed++; $display("FAIL miss_held: got %0d busy cycles want 3", held_cnt); end
        if (unstable != 0) begin tests_failed++; $display("FAIL miss_stable: got %0d changes want 0", unstable); end
        if (late_drop != 0) begin tests_failed++; $display("FAIL miss_we_drop: got %0d late cycles want 0", late_drop); end
        if (mem[4] !== 32'h04030201) begin tests_failed++; $display("FAIL miss_read16: got %h want 04030201", mem[4]); end
        stall_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_stalls();
        clear_log();
        pulse_start(32'd128, 16'd8);
        tx_bytes = '{8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h78, 8'h56, 8'h34, 8'h12};
        send_stream(1'b1);
        wait_done("stall");
        tests_run += 6;
        if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL stall_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_data_q[0] !== 32'hABCDEF12) begin tests_failed++; $display("FAIL stall_data0: got %h want abcdef12", wr_data_q[0]); end
        if (wr_data_q[1] !== 32'h12345678) begin tests_failed++; $display("FAIL stall_data1: got %h want 12345678", wr_data_q[1]); end
        if (wr_addr_q[1] !== 32'd132) begin tests_failed++; $display("FAIL stall_addr1: got %h want 84", wr_addr_q[1]); end
        if (ready_bad != 0) begin tests_failed++; $display("FAIL stall_ready: got %0d ready cycles in ISSUE/SETTLE want 0", ready_bad); end
        if (mem[32] !== 32'hABCDEF12) begin tests_failed++; $display("FAIL stall_read128: got %h want abcdef12", mem[32]); end
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start(32'd192, 16'd8);
        tx_bytes = '{8'h01, 8'h02};
        send_stream(1'b0);
        pulse_start(32'd400, 16'd4);
        tx_bytes = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_stream(1'b0);
        wait_done("ignore");
        tests_run += 5;
        if (wr_addr_q.size() != 2) begin tests_failed++; $display("FAIL ignore_count: got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q[0] !== 32'd192) begin tests_failed++; $display("FAIL ignore_addr0: got %h want c0", wr_addr_q[0]); end
        if (wr_data_q[0] !== 32'h04030201) begin tests_failed++; $display("FAIL ignore_data0: got %h want 04030201", wr_data_q[0]); end
        if (wr_addr_q[1] !== 32'd196) begin tests_failed++; $display("FAIL ignore_addr1: got %h want c4", wr_addr_q[1]); end
        if (wr_data_q[1] !== 32'h08070605) begin tests_failed++; $display("FAIL ignore_data1: got %h want 08070605", wr_data_q[1]); end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        mem[8] = 32'hDEADBEEF;
        pulse_start(32'd32, 16'd4);
        tx_bytes = '{8'h11, 8'h22};
        send_stream(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run += 5;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done: got %b want 0", done); end
        if (cache_address !== 32'h0) begin tests_failed++; $display("FAIL rstmid_addr: got %h want 0", cache_address); end
        if (cache_data_in !== 32'h0) begin tests_failed++; $display("FAIL rstmid_data: got %h want 0", cache_data_in); end
        if (cache_write_enable !== 4'h0) begin tests_failed++; $display("FAIL rstmid_we: got %b want 0000", cache_write_enable); end
        repeat (10) @(negedge clk);
        tests_run += 3;
        if (wr_addr_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_writes: got %0d want 0", wr_addr_q.size()); end
        if (mem[8] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rstmid_mem: got %h want deadbeef", mem[8]); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle_done: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pulse_start(32'd38, 16'd2);
        tx_bytes = '{8'h5A, 8'hA5};
        send_stream(1'b0);
        wait_done("b2b");
        tests_run += 4;
        if (wr_addr_q.size() != 1) begin tests_failed++; $display("FAIL b2b_count: got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q[0] !== 32'd36) begin tests_failed++; $display("FAIL b2b_addr: got %h want 24", wr_addr_q[0]); end
        if (wr_data_q[0] !== 32'hA55A0000) begin tests_failed++; $display("FAIL b2b_data: got %h want a55a0000", wr_data_q[0]); end
        if (wr_we_q[0] !== 4'b1100) begin tests_failed++; $display("FAIL b2b_we: got %b want 1100", wr_we_q[0]); end
    endtask

    initial begin
        test_reset();
        test_zero_length();
        test_aligned();
        test_unaligned();
        test_miss();
        test_stalls();
        test_start_ignored();
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
